// File: rtl/partition_sweep_pkg.sv
// Shared state encoding and result-width helpers for the partition sweep meter.
package partition_sweep_pkg;

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} sweep_state_e;

  function automatic int unsigned err_width(input int unsigned ni);
    return ni + 1;
  endfunction

  function automatic int unsigned hd_width(input int unsigned ni, input int unsigned no);
    return ni + $clog2(no) + 1;
  endfunction

  function automatic int unsigned aed_width(input int unsigned ni, input int unsigned no);
    return ni + no;
  endfunction

endpackage

// File: rtl/sweep_err_accum.sv
// Per-sample error metrics between exact and approximate partition outputs,
// accumulated into registers with synchronous clear and sample enable.
module sweep_err_accum
  import partition_sweep_pkg::*;
#(
  parameter int unsigned NI = 7,
  parameter int unsigned NO = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         en,
  input  logic [NO-1:0]                po_exact,
  input  logic [NO-1:0]                po_approx,
  output logic [err_width(NI)-1:0]     err_cnt,
  output logic [hd_width(NI, NO)-1:0]  hd_sum,
  output logic [aed_width(NI, NO)-1:0] aed_sum,
  output logic [NO-1:0]                max_aed
);

  localparam int unsigned EW = err_width(NI);
  localparam int unsigned HW = hd_width(NI, NO);
  localparam int unsigned AW = aed_width(NI, NO);
  localparam int unsigned PW = $clog2(NO + 1);

  logic [NO-1:0] diff;
  logic [NO-1:0] abs_err;
  logic [PW-1:0] pop;

  logic [EW-1:0] err_q;
  logic [HW-1:0] hd_q;
  logic [AW-1:0] aed_q;
  logic [NO-1:0] max_q;

  always_comb begin
    diff    = po_exact ^ po_approx;
    abs_err = (po_exact >= po_approx) ? (po_exact - po_approx) : (po_approx - po_exact);
    pop     = '0;
    for (int i = 0; i < NO; i++) begin
      pop = pop + PW'(diff[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      hd_q  <= '0;
      aed_q <= '0;
      max_q <= '0;
    end else if (clear) begin
      err_q <= '0;
      hd_q  <= '0;
      aed_q <= '0;
      max_q <= '0;
    end else if (en) begin
      err_q <= err_q + EW'(diff != '0);
      hd_q  <= hd_q + HW'(pop);
      aed_q <= aed_q + AW'(abs_err);
      if (abs_err > max_q) begin
        max_q <= abs_err;
      end
    end
  end

  assign err_cnt = err_q;
  assign hd_sum  = hd_q;
  assign aed_sum = aed_q;
  assign max_aed = max_q;

endmodule

// File: rtl/partition_sweep_meter.sv
// Exhaustively sweeps all 2^NI partition inputs and accumulates the error
// metrics between exact and approximate outputs returned LAT cycles later.
module partition_sweep_meter
  import partition_sweep_pkg::*;
#(
  parameter int unsigned NI  = 7,
  parameter int unsigned NO  = 4,
  parameter int unsigned LAT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  output logic [NI-1:0]                pi_out,
  input  logic [NO-1:0]                po_exact,
  input  logic [NO-1:0]                po_approx,
  output logic                         busy,
  output logic                         done,
  output logic [err_width(NI)-1:0]     err_cnt,
  output logic [hd_width(NI, NO)-1:0]  hd_sum,
  output logic [aed_width(NI, NO)-1:0] aed_sum,
  output logic [NO-1:0]                max_aed
);

  localparam int unsigned DW = (LAT > 1) ? $clog2(LAT) : 1;

  sweep_state_e  state_q;
  logic [NI-1:0] pi_q;
  logic [DW-1:0] drain_q;
  logic          busy_q;
  logic          done_q;

  logic issue;
  logic sample_valid;
  logic acc_clear;
  logic acc_en;

  assign issue     = (state_q == StSweep);
  assign acc_clear = ((state_q == StIdle) || (state_q == StDone)) && start && !abort;
  assign acc_en    = sample_valid && ((state_q == StSweep) || (state_q == StDrain));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pi_q    <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state_q <= StIdle;
      pi_q    <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StSweep;
            pi_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StSweep: begin
          // Wraps to zero after the last vector and stays there.
          pi_q <= pi_q + NI'(1);
          if (pi_q == '1) begin
            if (LAT > 0) begin
              state_q <= StDrain;
              drain_q <= '0;
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (drain_q == DW'(LAT - 1)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Valid bit travels alongside each issued vector through the partition latency.
  if (LAT == 0) begin : g_no_pipe
    assign sample_valid = issue;
  end else begin : g_pipe
    logic [LAT-1:0] vpipe_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vpipe_q <= '0;
      end else if (abort) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q <= LAT'({vpipe_q, issue});
      end
    end
    assign sample_valid = vpipe_q[LAT-1];
  end

  sweep_err_accum #(
    .NI(NI),
    .NO(NO)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clear),
    .en       (acc_en),
    .po_exact (po_exact),
    .po_approx(po_approx),
    .err_cnt  (err_cnt),
    .hd_sum   (hd_sum),
    .aed_sum  (aed_sum),
    .max_aed  (max_aed)
  );

  assign pi_out = pi_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_partition_sweep_meter.sv
// Bench: two meters (LAT=0 and LAT=2) share start/abort; a cycle-level model
// predicts pi_out/busy/done and the final metrics from a direct sum over all vectors.
module tb_partition_sweep_meter;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  int   mode;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [6:0]  pi0, pi2;
  logic [3:0]  pe0, pa0, pe2, pa2;
  logic        busy0, done0, busy2, done2;
  logic [7:0]  err0, err2;
  logic [9:0]  hd0, hd2;
  logic [10:0] aed0, aed2;
  logic [3:0]  max0, max2;
  logic [6:0]  s1, s2;

  int mst[2];
  int mk[2];
  int mmode[2];
  int lat[2] = '{0, 2};

  always #5 clk = ~clk;

  function automatic logic [3:0] approx_of(input int md, input logic [3:0] ex);
    case (md)
      1:       return ex ^ 4'b0001;
      2:       return 4'd0;
      3:       return ~ex;
      default: return ex;
    endcase
  endfunction

  // Partition under test: exact = pi[3:0]; LAT=2 copy goes through two registers.
  assign pe0 = pi0[3:0];
  assign pa0 = approx_of(mode, pe0);
  always @(posedge clk) begin
    s1 <= pi2;
    s2 <= s1;
  end
  assign pe2 = s2[3:0];
  assign pa2 = approx_of(mode, pe2);

  partition_sweep_meter #(.NI(7), .NO(4), .LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pi_out(pi0),
    .po_exact(pe0), .po_approx(pa0), .busy(busy0), .done(done0),
    .err_cnt(err0), .hd_sum(hd0), .aed_sum(aed0), .max_aed(max0)
  );

  partition_sweep_meter #(.NI(7), .NO(4), .LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pi_out(pi2),
    .po_exact(pe2), .po_approx(pa2), .busy(busy2), .done(done2),
    .err_cnt(err2), .hd_sum(hd2), .aed_sum(aed2), .max_aed(max2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void metrics(input int md, output int e, output int h, output int s,
                                  output int m);
    int ex, ap, d, a;
    e = 0; h = 0; s = 0; m = 0;
    for (int v = 0; v < 128; v++) begin
      ex = v % 16;
      ap = int'(approx_of(md, 4'(ex)));
      d  = ex ^ ap;
      a  = (ex > ap) ? ex - ap : ap - ex;
      if (d != 0) e++;
      h += $countones(d);
      s += a;
      if (a > m) m = a;
    end
  endfunction

  // Model: state per instance (0 idle, 1 sweeping/draining, 2 done), start cycle k.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || abort) mst[i] = 0;
      else if (mst[i] != 1 && start) begin
        mst[i] = 1; mk[i] = cyc; mmode[i] = mode;
      end else if (mst[i] == 1 && cyc == mk[i] + 128 + lat[i]) mst[i] = 2;
    end
    cyc++;
  end

  task automatic check_inst(input int i, input logic [6:0] p, input logic b, input logic d,
                            input logic [7:0] e, input logic [9:0] h, input logic [10:0] s,
                            input logic [3:0] m);
    int ep, xe, xh, xs, xm;
    string t;
    t  = (i == 0) ? "lat0" : "lat2";
    ep = (mst[i] == 1 && cyc - mk[i] - 1 < 128) ? cyc - mk[i] - 1 : 0;
    chk({t, ".pi_out"}, int'(p), ep);
    chk({t, ".busy"}, int'(b), int'(mst[i] == 1));
    chk({t, ".done"}, int'(d), int'(mst[i] == 2));
    if (mst[i] == 2) begin
      metrics(mmode[i], xe, xh, xs, xm);
      chk({t, ".err_cnt"}, int'(e), xe);
      chk({t, ".hd_sum"}, int'(h), xh);
      chk({t, ".aed_sum"}, int'(s), xs);
      chk({t, ".max_aed"}, int'(m), xm);
    end
  endtask

  task automatic zero_check(input string t);
    chk({t, ".pi0"}, int'(pi0), 0);   chk({t, ".pi2"}, int'(pi2), 0);
    chk({t, ".busy0"}, int'(busy0), 0); chk({t, ".busy2"}, int'(busy2), 0);
    chk({t, ".done0"}, int'(done0), 0); chk({t, ".done2"}, int'(done2), 0);
    chk({t, ".err0"}, int'(err0), 0); chk({t, ".err2"}, int'(err2), 0);
    chk({t, ".hd0"}, int'(hd0), 0);   chk({t, ".hd2"}, int'(hd2), 0);
    chk({t, ".aed0"}, int'(aed0), 0); chk({t, ".aed2"}, int'(aed2), 0);
    chk({t, ".max0"}, int'(max0), 0); chk({t, ".max2"}, int'(max2), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) zero_check("in_reset");
    else begin
      check_inst(0, pi0, busy0, done0, err0, hd0, aed0, max0);
      check_inst(1, pi2, busy2, done2, err2, hd2, aed2, max2);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick(1);
  endtask

  // Full sweep with literal done timing and results; optional start pulse mid-sweep.
  task automatic sweep(input int md, input int e, input int h, input int s, input int m,
                       input bit pulse);
    int k;
    mode = md;
    k = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    if (pulse) begin
      wait_cyc(k + 40);
      start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    wait_cyc(k + 128); @(negedge clk);
    chk("lit.done0_early", int'(done0), 0);
    wait_cyc(k + 129); @(negedge clk);
    chk("lit.done0", int'(done0), 1);
    chk("lit.err0", int'(err0), e); chk("lit.hd0", int'(hd0), h);
    chk("lit.aed0", int'(aed0), s); chk("lit.max0", int'(max0), m);
    wait_cyc(k + 130); @(negedge clk);
    chk("lit.done2_early", int'(done2), 0);
    wait_cyc(k + 131); @(negedge clk);
    chk("lit.done2", int'(done2), 1);
    chk("lit.err2", int'(err2), e); chk("lit.hd2", int'(hd2), h);
    chk("lit.aed2", int'(aed2), s); chk("lit.max2", int'(max2), m);
    tick(3);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
    tick(3);
    @(negedge clk);
    zero_check("reset");
    tick(1);
    rst_n = 1'b1;
    tick(2);

    sweep(0, 0, 0, 0, 0, 1'b0);
    sweep(1, 128, 128, 128, 1, 1'b0);
    sweep(2, 120, 256, 960, 15, 1'b0);
    sweep(3, 128, 512, 1024, 15, 1'b0);

    // Abort mid-sweep, then abort+start together from IDLE, then a clean sweep.
    mode = 1;
    k = cyc;
    start = 1'b1; tick(1); start = 1'b0;
    wait_cyc(k + 50);
    abort = 1'b1; tick(1); abort = 1'b0;
    @(negedge clk);
    chk("abort.busy0", int'(busy0), 0); chk("abort.busy2", int'(busy2), 0);
    chk("abort.pi0", int'(pi0), 0);
    tick(5);
    start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_wins.busy0", int'(busy0), 0); chk("abort_wins.busy2", int'(busy2), 0);
    tick(150);
    sweep(2, 120, 256, 960, 15, 1'b0);

    // Asynchronous reset mid-sweep, then a sweep with a stray start pulse.
    mode = 2;
    k = cyc;
    start = 1'b1; tick(1); start = 1'b0;
    wait_cyc(k + 70);
    rst_n = 1'b0;
    #1;
    zero_check("async_reset");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    sweep(1, 128, 128, 128, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
